// File: rtl/cpu_accel_pkg.sv
// rtl/cpu_accel_pkg.sv - shared state encodings and register map for the CPU/accelerator handshake
// Ports: none (package).
package cpu_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RESULT  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_RESULT  = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // STATUS layout: [2:0] state, [3] error, [4] irq_pend
  function automatic logic [31:0] status_word(input state_t st, input logic err, input logic pend);
    return {27'd0, pend, err, st};
  endfunction

endpackage

// File: rtl/cpu_accel_handshake_ctrl_if.sv
// rtl/cpu_accel_handshake_ctrl_if.sv - Avalon-MM slave bus plus accelerator handshake signals
// Ports (slave = controller view):
//   in : address[1:0], chipselect, write_n, writedata[31:0], accel_busy, accel_done, accel_result
//   out: readdata[31:0], irq, accel_start, done_read
interface cpu_accel_handshake_ctrl_if #(
  parameter int RESULT_W = 8
) ();

  logic [1:0]          address;
  logic                chipselect;
  logic                write_n;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic                irq;
  logic                accel_start;
  logic                accel_busy;
  logic                accel_done;
  logic [RESULT_W-1:0] accel_result;
  logic                done_read;

  modport slave (
    input  address, chipselect, write_n, writedata,
    input  accel_busy, accel_done, accel_result,
    output readdata, irq, accel_start, done_read
  );

  modport master (
    output address, chipselect, write_n, writedata,
    output accel_busy, accel_done, accel_result,
    input  readdata, irq, accel_start, done_read
  );

endinterface

// File: rtl/cpu_accel_watchdog.sv
// rtl/cpu_accel_watchdog.sv - loadable down-counter that flags the cycle its count reaches zero
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   i_load          : load i_load_val into the count (priority over enable)
//   i_load_val      : reload value; 0 leaves the watchdog idle
//   i_enable        : decrement once per cycle while the count is non-zero
//   o_expired       : high in the cycle whose edge takes the count from 1 to 0
module cpu_accel_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [TIMEOUT_W-1:0] i_load_val,
  input  logic                 i_enable,
  output logic                 o_expired
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Flag one cycle early so the owner changes state on the same edge the count hits zero;
  // a count parked at zero (TIMEOUT=0) never fires.
  assign o_expired = i_enable && (r_count == TIMEOUT_W'(1));

endmodule

// File: rtl/cpu_accel_handshake_ctrl.sv
// rtl/cpu_accel_handshake_ctrl.sv - CPU-visible start/result/release handshake to an accelerator with watchdog
// Ports:
//   clk     : single clock
//   reset_n : async active-low reset
//   bus     : slave modport (Avalon-MM register port, irq, accel_start/busy/done/result, done_read)
module cpu_accel_handshake_ctrl
  import cpu_accel_pkg::*;
#(
  parameter int TIMEOUT_W = 16,
  parameter int RESULT_W  = 8
) (
  input logic                     clk,
  input logic                     reset_n,
  cpu_accel_handshake_ctrl_if.slave bus
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_error;
  logic                  r_irq_pend;
  logic                  r_irq_en;
  logic                  r_accel_start;
  logic                  r_done_read;
  logic [RESULT_W-1:0]   r_result;
  logic [TIMEOUT_W-1:0]  r_timeout;

  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_status_wr;
  logic                  w_timeout_wr;
  logic                  w_abort;
  logic                  w_start;
  logic                  w_wd_en;
  logic                  w_wd_expired;
  logic                  w_capture;
  logic                  w_timed_out;
  logic                  w_ack;
  logic [31:0]           w_rdata;
  logic                  w_unused_wdata;

  assign w_wr         = bus.chipselect & ~bus.write_n;
  assign w_ctrl_wr    = w_wr && (bus.address == ADDR_CTRL);
  assign w_status_wr  = w_wr && (bus.address == ADDR_STATUS);
  assign w_timeout_wr = w_wr && (bus.address == ADDR_TIMEOUT);
  assign w_abort      = w_ctrl_wr && bus.writedata[CTRL_ABORT_BIT];
  // Abort wins over start in the same write; start is only honoured from IDLE.
  assign w_start      = w_ctrl_wr && bus.writedata[CTRL_START_BIT] && !w_abort && (r_state == ST_IDLE);
  assign w_wd_en      = (r_state == ST_START) || (r_state == ST_RUN);
  assign w_unused_wdata = ^bus.writedata;

  // The count is captured from TIMEOUT only at start, so later TIMEOUT writes wait for the next run.
  cpu_accel_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_load     (w_start),
    .i_load_val (r_timeout),
    .i_enable   (w_wd_en),
    .o_expired  (w_wd_expired)
  );

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_timed_out  = 1'b0;
    w_ack        = 1'b0;
    if (w_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) w_next_state = ST_START;
        end
        ST_START: begin
          if (w_wd_expired) begin
            w_next_state = ST_ERROR;
            w_timed_out  = 1'b1;
          end else if (bus.accel_busy) begin
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_wd_expired) begin
            w_next_state = ST_ERROR;
            w_timed_out  = 1'b1;
          end else if (bus.accel_done) begin
            w_next_state = ST_RESULT;
            w_capture    = 1'b1;
          end
        end
        ST_RESULT: begin
          if (w_status_wr) begin
            w_next_state = ST_RELEASE;
            w_ack        = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!bus.accel_done) w_next_state = ST_IDLE;
        end
        ST_ERROR: begin
          w_next_state = ST_ERROR;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_accel_start <= 1'b0;
      r_done_read   <= 1'b0;
      r_error       <= 1'b0;
      r_irq_pend    <= 1'b0;
      r_irq_en      <= 1'b0;
      r_result      <= '0;
      r_timeout     <= '1;
    end else begin
      r_state       <= w_next_state;
      // Decoded from the next state so both strobes are flop outputs and mutually exclusive.
      r_accel_start <= (w_next_state == ST_START);
      r_done_read   <= (w_next_state == ST_RELEASE);
      if (w_ctrl_wr)    r_irq_en  <= bus.writedata[CTRL_IRQ_EN_BIT];
      if (w_timeout_wr) r_timeout <= bus.writedata[TIMEOUT_W-1:0];
      if (w_capture)    r_result  <= bus.accel_result;
      if (w_abort) begin
        r_error    <= 1'b0;
        r_irq_pend <= 1'b0;
      end else begin
        if (w_timed_out) begin
          r_error    <= 1'b1;
          r_irq_pend <= 1'b1;
        end
        if (w_capture) r_irq_pend <= 1'b1;
        if (w_ack)     r_irq_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_CTRL:   w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      ADDR_STATUS: w_rdata = status_word(r_state, r_error, r_irq_pend);
      ADDR_RESULT: w_rdata = 32'(r_result);
      default:     w_rdata = 32'(r_timeout);
    endcase
  end

  assign bus.readdata    = w_rdata;
  assign bus.irq         = r_irq_pend & r_irq_en;
  assign bus.accel_start = r_accel_start;
  assign bus.done_read   = r_done_read;

endmodule

// File: doc/cpu_accel_handshake_ctrl.md
CPU_ACCEL_HANDSHAKE_CTRL -- requirements
Module: cpu_accel_handshake_ctrl

Interface
REQ-001 Parameter TIMEOUT_W, default 16, width of the watchdog counter and TIMEOUT register.
REQ-002 Parameter RESULT_W, default 8, width of the accelerator result (RESULT_W <= 32).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  combinational read data, zero-extended, valid whenever address is stable.
REQ-010 irq  output  1  level interrupt = irq_pend AND irq_en.
REQ-011 accel_start  output  1  start request to the accelerator.
REQ-012 accel_busy  input  1  accelerator has accepted start.
REQ-013 accel_done  input  1  accelerator result valid; held until released.
REQ-014 accel_result  input  RESULT_W  accelerator result, valid while accel_done=1.
REQ-015 done_read  output  1  release to the accelerator that the result has been consumed.

Function
REQ-016 Write = chipselect AND NOT write_n; register map: 0 CTRL (W: bit0 start, bit1 abort, bit2 irq_en; R: irq_en in bit2), 1 STATUS (R: [2:0] state, bit3 error, bit4 irq_pend), 2 RESULT (R), 3 TIMEOUT (R/W, TIMEOUT_W bits).
REQ-017 FSM states: IDLE=0, START=1, RUN=2, RESULT=3, RELEASE=4, ERROR=5.
REQ-018 IDLE -> START on CTRL write with bit0=1; start writes in any other state are ignored.
REQ-019 START: accel_start=1; -> RUN on the first cycle accel_busy=1.
REQ-020 RUN: accel_start=0; -> RESULT on the first cycle accel_done=1, capturing accel_result into RESULT on that edge and setting irq_pend.
REQ-021 RESULT: waits for a STATUS-address write (any data) as CPU acknowledge; that write clears irq_pend and moves to RELEASE.
REQ-022 RELEASE: done_read=1; -> IDLE on the first cycle accel_done=0.
REQ-023 Watchdog: on entry to START it loads TIMEOUT, decrements once per cycle in START and RUN; reaching 0 moves to ERROR, sets error and irq_pend; TIMEOUT=0 disables the watchdog.
REQ-024 ERROR: accel_start=0, done_read=0; exits only via abort.
REQ-025 CTRL write with bit1=1 in any state -> IDLE next cycle, clears error and irq_pend, drops accel_start and done_read; abort takes priority over start in the same write.
REQ-026 irq_en updates on every CTRL write regardless of state.
REQ-027 A TIMEOUT write during START or RUN does not affect the running count; it applies from the next start.
REQ-028 accel_start and done_read are registered outputs, glitch-free, never high simultaneously.
REQ-029 RESULT holds its value until the next capture; it is not cleared by abort.

Reset
REQ-030 On reset_n=0: state IDLE, accel_start=0, done_read=0, irq_pend=0, error=0, irq_en=0, RESULT=0, TIMEOUT=all ones, watchdog=0; effective immediately, including mid-transaction.

Structure
REQ-031 State encodings and register-address constants live in shared package cpu_accel_pkg.
REQ-032 The watchdog is one sub-module, cpu_accel_watchdog (load, enable, count, expired).

Verification
REQ-033 Normal: TIMEOUT=100, start; busy at cycle 3, done with result 0x5A at cycle 10 -> RESULT reads 0x5A, irq=1 if irq_en; STATUS write -> done_read=1 until done drops, then state 0.
REQ-034 Timeout: TIMEOUT=5, start, busy never asserted -> state 5, error=1 exactly 5 cycles after START entry; abort -> state 0, error=0.
REQ-035 Disabled watchdog: TIMEOUT=0, start, busy after 70000 cycles -> no ERROR, proceeds to RUN.
REQ-036 Simultaneous: CTRL write 0x3 in IDLE -> remains IDLE, accel_start never asserted; start during RUN -> ignored.
REQ-037 Reset mid-operation: reset_n pulsed low in RELEASE -> done_read=0, state 0 without waiting for a clock edge.
